motion_update_velocity_scheduler: RTL and testbench



---
 rtl/md_motion_update_pkg.sv | 31 +++
 rtl/velocity_integrator.sv | 43 ++++
 rtl/motion_update_velocity_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_motion_update_velocity_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_motion_update_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_motion_update_pkg
//  Brief    : Shared state encoding and sizing constants for the
//             motion-update velocity scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package md_motion_update_pkg;

    // Default width of one cell coordinate; cells are numbered 1..NUM per axis
    localparam int CELL_ID_WIDTH_DEF = 4;
    localparam int NUM_CELL_DEF      = 4;

    // Depth of the particle-read valid pipeline (2-cycle cache + 1 register)
    localparam int VALID_PIPE_DEPTH  = 3;

    // Idle cycles spent in FINISH before the done pulse
    localparam int FINISH_CYCLES     = 3;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_RD_COUNT     = 3'd1,
        S_WAIT_COUNT   = 3'd2,
        S_RD_PARTICLES = 3'd3,
        S_DRAIN        = 3'd4,
        S_NEXT_CELL    = 3'd5,
        S_FINISH       = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/velocity_integrator.sv
`default_nettype none
// ============================================================================
//  Module   : velocity_integrator
//  Brief    : Three-lane v + (f >>> DT_SHIFT) with a single output register.
//             Wraps on overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module velocity_integrator #(
    parameter int DATA_WIDTH = 32,
    parameter int DT_SHIFT   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3*DATA_WIDTH-1:0] vel_i,
    input  logic [3*DATA_WIDTH-1:0] frc_i,
    output logic [3*DATA_WIDTH-1:0] vel_new_o
);

    logic [3*DATA_WIDTH-1:0] vel_new_d;
    logic [3*DATA_WIDTH-1:0] vel_new_q;

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] w_v;
        logic signed [DATA_WIDTH-1:0] w_f;
        assign w_v = vel_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_f = frc_i[gi*DATA_WIDTH +: DATA_WIDTH];
        // Arithmetic shift keeps the sign of negative forces
        assign vel_new_d[gi*DATA_WIDTH +: DATA_WIDTH] = w_v + (w_f >>> DT_SHIFT);
    end

    // Register the updated velocity every cycle; validity is tracked by the caller
    always_ff @(posedge clk) begin
        if (rst) begin
            vel_new_q <= '0;
        end else begin
            vel_new_q <= vel_new_d;
        end
    end

    assign vel_new_o = vel_new_q;

endmodule
`default_nettype wire

// File: rtl/motion_update_velocity_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : motion_update_velocity_scheduler
//  Brief    : Sweeps every cell (z fastest, then y, then x), reads the particle
//             count at address 0, reads each particle, and streams updated
//             velocities with their destination cell.
//  Revision : 1.0 - initial release
// ============================================================================
module motion_update_velocity_scheduler
    import md_motion_update_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int CELL_ID_WIDTH = CELL_ID_WIDTH_DEF,
    parameter int NUM_CELL_X    = NUM_CELL_DEF,
    parameter int NUM_CELL_Y    = NUM_CELL_DEF,
    parameter int NUM_CELL_Z    = NUM_CELL_DEF,
    parameter int DT_SHIFT      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3*DATA_WIDTH-1:0]    in_velocity,
    input  logic [3*DATA_WIDTH-1:0]    in_force,
    input  logic [3*CELL_ID_WIDTH-1:0] in_dst_cell,
    output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell,
    output logic [ADDR_WIDTH-1:0]      out_rd_address,
    output logic                       out_rden,
    output logic                       motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]    out_data,
    output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
    output logic                       out_data_valid,
    output logic                       done
);

    localparam logic [CELL_ID_WIDTH-1:0] C_NUM_X = CELL_ID_WIDTH'(NUM_CELL_X);
    localparam logic [CELL_ID_WIDTH-1:0] C_NUM_Y = CELL_ID_WIDTH'(NUM_CELL_Y);
    localparam logic [CELL_ID_WIDTH-1:0] C_NUM_Z = CELL_ID_WIDTH'(NUM_CELL_Z);
    localparam logic [CELL_ID_WIDTH-1:0] C_ONE   = CELL_ID_WIDTH'(1);
    localparam logic [1:0]               C_FIN_LAST = 2'(FINISH_CYCLES - 1);

    state_e                         state_q, state_d;
    logic [CELL_ID_WIDTH-1:0]       cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]          count_q, count_d;
    logic                           wait_q, wait_d;
    logic [1:0]                     fin_q, fin_d;
    logic [VALID_PIPE_DEPTH-1:0]    vpipe_q, vpipe_d;
    logic                           done_q, done_d;
    logic [3*CELL_ID_WIDTH-1:0]     dst_q;
    logic [3*DATA_WIDTH-1:0]        w_vel_new;
    logic [ADDR_WIDTH-1:0]          w_count;

    assign w_count = in_velocity[ADDR_WIDTH-1:0];

    // Next-state logic for the cell sweep
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cz_d    = cz_q;
        addr_d  = addr_q;
        count_d = count_q;
        wait_d  = wait_q;
        fin_d   = fin_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_COUNT;
                    cx_d    = C_ONE;
                    cy_d    = C_ONE;
                    cz_d    = C_ONE;
                end
            end
            S_RD_COUNT: begin
                state_d = S_WAIT_COUNT;
                wait_d  = 1'b0;
            end
            S_WAIT_COUNT: begin
                // Count word arrives on the second wait cycle
                if (wait_q) begin
                    count_d = w_count;
                    addr_d  = ADDR_WIDTH'(1);
                    state_d = (w_count == '0) ? S_NEXT_CELL : S_RD_PARTICLES;
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_RD_PARTICLES: begin
                if (addr_q == count_q) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Leave once only the output stage may still be busy, so the
                // sweep steps on in the cycle right after the final output
                if (vpipe_q[VALID_PIPE_DEPTH-2:0] == '0) begin
                    state_d = S_NEXT_CELL;
                end
            end
            S_NEXT_CELL: begin
                state_d = S_RD_COUNT;
                if (cz_q != C_NUM_Z) begin
                    cz_d = cz_q + 1'b1;
                end else if (cy_q != C_NUM_Y) begin
                    cy_d = cy_q + 1'b1;
                    cz_d = C_ONE;
                end else if (cx_q != C_NUM_X) begin
                    cx_d = cx_q + 1'b1;
                    cy_d = C_ONE;
                    cz_d = C_ONE;
                end else begin
                    state_d = S_FINISH;
                    fin_d   = 2'd0;
                end
            end
            S_FINISH: begin
                if (fin_q == C_FIN_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    fin_d = fin_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Valid pipeline tracks particle reads only; count reads never produce output
    assign vpipe_d = {vpipe_q[VALID_PIPE_DEPTH-2:0], (state_q == S_RD_PARTICLES)};

    // State, sweep position and pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cx_q    <= C_ONE;
            cy_q    <= C_ONE;
            cz_q    <= C_ONE;
            addr_q  <= '0;
            count_q <= '0;
            wait_q  <= 1'b0;
            fin_q   <= 2'd0;
            vpipe_q <= '0;
            done_q  <= 1'b0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cz_q    <= cz_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            fin_q   <= fin_d;
            vpipe_q <= vpipe_d;
            done_q  <= done_d;
            dst_q   <= in_dst_cell;
        end
    end

    velocity_integrator #(
        .DATA_WIDTH (DATA_WIDTH),
        .DT_SHIFT   (DT_SHIFT)
    ) u_integrator (
        .clk       (clk),
        .rst       (rst),
        .vel_i     (in_velocity),
        .frc_i     (in_force),
        .vel_new_o (w_vel_new)
    );

    assign out_rden             = (state_q == S_RD_COUNT) || (state_q == S_RD_PARTICLES);
    assign out_rd_address       = (state_q == S_RD_PARTICLES) ? addr_q : '0;
    assign out_rd_cell          = out_rden ? {cx_q, cy_q, cz_q} : '0;
    assign motion_update_enable = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign out_data_valid       = vpipe_q[VALID_PIPE_DEPTH-1];
    assign out_data             = out_data_valid ? w_vel_new : '0;
    assign out_data_dst_cell    = out_data_valid ? dst_q : '0;
    assign done                 = done_q;

endmodule
`default_nettype wire

// File: tb/tb_motion_update_velocity_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motion_update_velocity_scheduler
//  Brief    : Randomized scoreboard bench with a cache model for the
//             motion-update velocity scheduler on a 2x2x2 grid.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_motion_update_velocity_scheduler;

    localparam int DW = 32, AW = 8, CW = 4;
    localparam int NX = 2, NY = 2, NZ = 2, DTS = 4;
    localparam int NCELL = NX * NY * NZ;
    localparam int MAXP = 6;

    logic clk = 1'b0;
    logic rst, start;
    logic [3*DW-1:0] in_velocity, in_force, out_data;
    logic [3*CW-1:0] in_dst_cell, out_rd_cell, out_data_dst_cell;
    logic [AW-1:0]   out_rd_address;
    logic out_rden, motion_update_enable, out_data_valid, done;

    always #5 clk = ~clk;

    motion_update_velocity_scheduler #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELL_ID_WIDTH(CW),
        .NUM_CELL_X(NX), .NUM_CELL_Y(NY), .NUM_CELL_Z(NZ), .DT_SHIFT(DTS)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_velocity(in_velocity), .in_force(in_force), .in_dst_cell(in_dst_cell),
        .out_rd_cell(out_rd_cell), .out_rd_address(out_rd_address), .out_rden(out_rden),
        .motion_update_enable(motion_update_enable), .out_data(out_data),
        .out_data_dst_cell(out_data_dst_cell), .out_data_valid(out_data_valid), .done(done)
    );

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cache contents: per cell a count and particle records at addresses 1..count
    int              cnt [NCELL];
    logic [3*DW-1:0] pv  [NCELL][MAXP+1];
    logic [3*DW-1:0] pf  [NCELL][MAXP+1];
    logic [3*CW-1:0] pd  [NCELL][MAXP+1];

    logic [3*CW+AW-1:0] req_q [$];
    logic [3*DW+3*CW-1:0] exp_q [$];
    int vcyc_q [$];
    int fall_cyc = -1, last_valid = -1;
    bit last_nonzero = 0, done_seen = 0, cell2_part = 0, prev_en = 0;
    bit d1_v = 0, d2_v = 0;
    logic [3*CW-1:0] d1_c = '0, d2_c = '0;
    logic [AW-1:0]   d1_a = '0, d2_a = '0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: v + floor(f / 2^DTS), wrapped to DW bits
    function automatic logic [DW-1:0] vnew(input logic [DW-1:0] v, input logic [DW-1:0] f);
        longint sv, sf, q;
        logic [63:0] full;
        sv = longint'($signed(v));
        sf = longint'($signed(f));
        q  = (sf >= 0) ? sf / 16 : -((-sf + 15) / 16);
        full = 64'(sv + q);
        return full[DW-1:0];
    endfunction

    function automatic logic [3*DW-1:0] integrate3(input logic [3*DW-1:0] v, input logic [3*DW-1:0] f);
        logic [3*DW-1:0] r;
        for (int k = 0; k < 3; k++) r[k*DW +: DW] = vnew(v[k*DW +: DW], f[k*DW +: DW]);
        return r;
    endfunction

    function automatic int cidx(input logic [3*CW-1:0] c);
        int x, y, z;
        x = int'(c[3*CW-1:2*CW]);
        y = int'(c[2*CW-1:CW]);
        z = int'(c[CW-1:0]);
        if (x < 1 || x > NX || y < 1 || y > NY || z < 1 || z > NZ) return -1;
        return ((x - 1) * NY + (y - 1)) * NZ + (z - 1);
    endfunction

    // Expected read order and output stream for one complete sweep
    task automatic prepare_expected();
        logic [3*CW-1:0] c;
        int ci;
        req_q.delete(); exp_q.delete(); vcyc_q.delete();
        for (int x = 1; x <= NX; x++)
            for (int y = 1; y <= NY; y++)
                for (int z = 1; z <= NZ; z++) begin
                    c  = {CW'(x), CW'(y), CW'(z)};
                    ci = cidx(c);
                    req_q.push_back({c, AW'(0)});
                    for (int a = 1; a <= cnt[ci]; a++) begin
                        req_q.push_back({c, AW'(a)});
                        exp_q.push_back({integrate3(pv[ci][a], pf[ci][a]), pd[ci][a]});
                    end
                end
        last_nonzero = (cnt[NCELL-1] > 0);
        fall_cyc = -1; last_valid = -1; done_seen = 0; cell2_part = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NCELL; i++) begin
            cnt[i] = $urandom_range(0, MAXP);
            for (int a = 0; a <= MAXP; a++) begin
                pv[i][a] = {$urandom, $urandom, $urandom};
                pf[i][a] = {$urandom, $urandom, $urandom};
                pd[i][a] = 12'($urandom);
            end
        end
    endtask

    // Cache model (2-cycle read latency) plus output monitor
    always @(negedge clk) begin : mon
        logic [3*DW-1:0] vel, frc;
        logic [3*CW-1:0] dst;
        logic [3*CW+AW-1:0] r;
        logic [3*DW+3*CW-1:0] e;
        int ci, rc;
        vel = {$urandom, $urandom, $urandom};
        frc = {$urandom, $urandom, $urandom};
        dst = 12'($urandom);
        if (d2_v) begin
            ci = cidx(d2_c);
            if (ci >= 0 && d2_a == 0) begin
                vel[AW-1:0] = AW'(cnt[ci]);
            end else if (ci >= 0 && int'(d2_a) <= MAXP) begin
                vel = pv[ci][d2_a]; frc = pf[ci][d2_a]; dst = pd[ci][d2_a];
            end
        end
        in_velocity = vel; in_force = frc; in_dst_cell = dst;
        d2_v = d1_v; d2_c = d1_c; d2_a = d1_a;
        d1_v = out_rden; d1_c = out_rd_cell; d1_a = out_rd_address;

        if (!rst) begin
            if (out_rden) begin
                if (req_q.size() == 0) fail_now("unexpected_read");
                else begin
                    r = req_q.pop_front();
                    chk("rd_cell", out_rd_cell, r[3*CW+AW-1:AW]);
                    chk("rd_addr", out_rd_address, r[AW-1:0]);
                end
                if (out_rd_address != 0) begin
                    vcyc_q.push_back(cyc);
                    if (out_rd_cell == 12'h112) cell2_part = 1;
                end
            end else begin
                chk("rd_addr_idle", out_rd_address, 0);
            end

            if (out_data_valid) begin
                if (exp_q.size() == 0) fail_now("unexpected_valid");
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[3*DW+3*CW-1:3*CW]);
                    chk("out_dst", out_data_dst_cell, e[3*CW-1:0]);
                end
                if (vcyc_q.size() == 0) fail_now("valid_without_read");
                else begin
                    rc = vcyc_q.pop_front();
                    chk("valid_latency", cyc, rc + 3);
                end
                last_valid = cyc;
            end else begin
                chk("data_idle_zero", {out_data, out_data_dst_cell}, 0);
            end

            if (prev_en && !motion_update_enable) begin
                fall_cyc = cyc;
                if (last_nonzero && last_valid >= 0) chk("enable_fall", cyc, last_valid + 2);
            end
            if (done) begin
                if (fall_cyc < 0) fail_now("done_without_enable_fall");
                else chk("done_delay", cyc, fall_cyc + 3);
                done_seen = 1;
            end
        end
        prev_en = motion_update_enable;
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input bit busy);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = busy && motion_update_enable && ($urandom_range(0, 5) == 0);
            if (done_seen) break;
        end
        start = 1'b0;
        if (!done_seen) fail_now("timeout_waiting_done");
        repeat (2) @(negedge clk);
        chk("reads_all_issued", req_q.size(), 0);
        chk("outputs_all_seen", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rden"}, out_rden, 0);
        chk({tag, "_rd_addr"}, out_rd_address, 0);
        chk({tag, "_rd_cell"}, out_rd_cell, 0);
        chk({tag, "_enable"}, motion_update_enable, 0);
        chk({tag, "_valid"}, out_data_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_dst"}, out_data_dst_cell, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk); rst = 1'b0;

        // Directed values: 10+32/16=12, wrap at 0x7FFFFFFF, negative force
        fill_random();
        for (int i = 0; i < NCELL; i++) cnt[i] = 0;
        cnt[0] = 3;
        pv[0][1] = {3{32'd10}};         pf[0][1] = {3{32'd32}};
        pv[0][2] = {3{32'h7FFF_FFFF}};  pf[0][2] = {3{32'd16}};
        pv[0][3] = {3{32'd0}};          pf[0][3] = {3{32'hFFFF_FFE0}};
        cnt[NCELL-1] = 2;
        prepare_expected();
        pulse_start();
        wait_done(0);

        // All cells empty: no outputs, done three cycles after enable falls
        for (int i = 0; i < NCELL; i++) cnt[i] = 0;
        prepare_expected();
        pulse_start();
        wait_done(0);

        // Random contents with extra start pulses while busy
        for (int run = 0; run < 3; run++) begin
            fill_random();
            cnt[NCELL-1] = $urandom_range(1, MAXP);
            prepare_expected();
            pulse_start();
            wait_done(1);
        end

        // Reset during particle reads of the second cell, then restart
        fill_random();
        cnt[1] = 4;
        prepare_expected();
        pulse_start();
        for (int i = 0; i < 500 && !cell2_part; i++) @(negedge clk);
        if (!cell2_part) fail_now("timeout_waiting_cell2");
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        #1 check_all_zero("midreset");
        prepare_expected();
        @(negedge clk); rst = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
